countdown_mod60: RTL and testbench

Settable 00–59 countdown timer: the down-counting counterpart of the free-running seconds counter. It counts from a loaded two-digit BCD value down to 00, one step per prescaled tick, then stops and pulses `done`. It drives the same pair of 7-segment digit displays directly. Prescaler, digit counters, control FSM and segment encoding are all internal, so the block sits between the board clock/buttons and the two displays.

---
 rtl/countdown_mod60.sv | 170 +++++++++++++++++
 tb/tb_countdown_mod60.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_mod60.sv
// ---------------------------------------------------------------------------
// countdown_mod60
//   Settable 00-59 countdown timer with built-in prescaler and 7-segment
//   encoding for two digit displays. Counts down one step per CLK_DIV clock
//   cycles from a loaded BCD value, stops at 00 and pulses done once.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low; clears all state
//   load         load clamped load_tens/load_units, return to IDLE
//   load_tens    tens digit to load (values >5 clamp to 5)
//   load_units   units digit to load (values >9 clamp to 9)
//   start        begin (IDLE) or resume (PAUSE) counting
//   pause        suspend counting while running
//   tens/units   current digits, binary
//   seg_tens/
//   seg_units    active-high segments, bit0=a .. bit6=g
//   running      high while counting
//   done         one-cycle pulse when the count reaches 00
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | loaded or reset, waiting for start
// RUN   | prescaler advancing, digits step on each tick
// PAUSE | prescaler and digits frozen, start resumes
// DONE  | reached 00, held until load or reset
// ---------------------------------------------------------------------------
module countdown_mod60 #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] load_tens,
  input  logic [3:0] load_units,
  input  logic       start,
  input  logic       pause,
  output logic [2:0] tens,
  output logic [3:0] units,
  output logic [6:0] seg_units,
  output logic [6:0] seg_tens,
  output logic       running,
  output logic       done
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q;
  logic [2:0]      tens_q;
  logic [3:0]      units_q;
  logic [PW-1:0]   presc_q;
  logic            running_q;
  logic            done_q;

  logic [2:0]      tens_d;
  logic [3:0]      units_d;
  logic [2:0]      ld_tens_c;
  logic [3:0]      ld_units_c;
  logic            tick;
  logic            value_zero;
  logic            last_step;

  always_comb begin
    ld_tens_c  = (load_tens  > 3'd5) ? 3'd5 : load_tens;
    ld_units_c = (load_units > 4'd9) ? 4'd9 : load_units;
    // Decremented value with borrow from units into tens.
    tens_d  = tens_q;
    units_d = units_q - 4'd1;
    if (units_q == 4'd0) begin
      units_d = 4'd9;
      tens_d  = tens_q - 3'd1;
    end
    tick       = (presc_q == PRESC_TC);
    value_zero = (tens_q == 3'd0) && (units_q == 4'd0);
    last_step  = (tens_q == 3'd0) && (units_q == 4'd1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tens_q    <= 3'd0;
      units_q   <= 4'd0;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        tens_q    <= ld_tens_c;
        units_q   <= ld_units_c;
        presc_q   <= '0;
        state_q   <= IDLE;
        running_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !value_zero) begin
              presc_q   <= '0;
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            // Pause beats a coincident tick; prescaler stays at terminal
            // count so the tick fires on the first cycle after resume.
            if (pause) begin
              state_q   <= PAUSE;
              running_q <= 1'b0;
            end else if (tick) begin
              presc_q <= '0;
              tens_q  <= tens_d;
              units_q <= units_d;
              if (last_step) begin
                state_q   <= DONE;
                running_q <= 1'b0;
                done_q    <= 1'b1;
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
          PAUSE: begin
            if (start && !value_zero) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          DONE: begin
          end
          default: begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  assign tens      = tens_q;
  assign units     = units_q;
  assign seg_tens  = seg7({1'b0, tens_q});
  assign seg_units = seg7(units_q);
  assign running   = running_q;
  assign done      = done_q;

endmodule

// File: tb/tb_countdown_mod60.sv
module tb_countdown_mod60;

  localparam int CLK_DIV = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [2:0] load_tens;
  logic [3:0] load_units;
  logic       start;
  logic       pause;
  logic [2:0] tens;
  logic [3:0] units;
  logic [6:0] seg_units;
  logic [6:0] seg_tens;
  logic       running;
  logic       done;

  countdown_mod60 #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_tens  (load_tens),
    .load_units (load_units),
    .start      (start),
    .pause      (pause),
    .tens       (tens),
    .units      (units),
    .seg_units  (seg_units),
    .seg_tens   (seg_tens),
    .running    (running),
    .done       (done)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: remaining seconds as a plain integer, RUN cycles
  // elapsed since the last step, and an operating mode.
  int m_val;
  int m_cnt;
  int m_mode;
  bit m_done;
  int done_pulses;
  logic [6:0] seg_tab [0:9];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_val  = 0;
    m_cnt  = 0;
    m_mode = M_IDLE;
    m_done = 0;
  endtask

  task automatic model_edge();
    int lt, lu;
    m_done = 0;
    if (load) begin
      lt = (int'(load_tens)  > 5) ? 5 : int'(load_tens);
      lu = (int'(load_units) > 9) ? 9 : int'(load_units);
      m_val  = lt * 10 + lu;
      m_cnt  = 0;
      m_mode = M_IDLE;
    end else if (m_mode == M_RUN && pause) begin
      m_mode = M_PAUSE;
    end else if (start && (m_mode == M_IDLE || m_mode == M_PAUSE) && m_val != 0) begin
      if (m_mode == M_IDLE) m_cnt = 0;
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      m_cnt++;
      if (m_cnt == CLK_DIV) begin
        m_cnt = 0;
        m_val--;
        if (m_val == 0) begin
          m_mode = M_DONE;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("tens",      32'(tens),      32'(m_val / 10));
    chk("units",     32'(units),     32'(m_val % 10));
    chk("seg_tens",  32'(seg_tens),  32'(seg_tab[m_val / 10]));
    chk("seg_units", 32'(seg_units), 32'(seg_tab[m_val % 10]));
    chk("running",   32'(running),   32'(m_mode == M_RUN));
    chk("done",      32'(done),      32'(m_done));
    if (done === 1'b1) done_pulses++;
  endtask

  task automatic step(input bit l, input int lt, input int lu, input bit s, input bit p);
    load       = l;
    load_tens  = 3'(lt);
    load_units = 4'(lu);
    start      = s;
    pause      = p;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    seg_tab[0] = 7'b0111111; seg_tab[1] = 7'b0000110; seg_tab[2] = 7'b1011011;
    seg_tab[3] = 7'b1001111; seg_tab[4] = 7'b1100110; seg_tab[5] = 7'b1101101;
    seg_tab[6] = 7'b1111101; seg_tab[7] = 7'b0000111; seg_tab[8] = 7'b1111111;
    seg_tab[9] = 7'b1101111;

    reset = 1'b0; load = 0; load_tens = 0; load_units = 0; start = 0; pause = 0;
    model_reset();
    #12;
    check_all();
    reset = 1'b1;

    // start with 00 after reset stays IDLE
    step(0, 0, 0, 1, 0);
    idle(2);

    // full countdown 12 -> 00 with borrow
    step(1, 1, 2, 0, 0);
    step(0, 0, 0, 1, 0);
    done_pulses = 0;
    idle(12 * CLK_DIV);
    chk("final_done", 32'(done), 32'd1);
    idle(3);
    chk("done_pulses", 32'(done_pulses), 32'd1);
    // start in DONE ignored
    step(0, 0, 0, 1, 0);
    idle(2);

    // load clamping
    step(1, 7, 12, 0, 0);
    chk("clamp_seg_tens",  32'(seg_tens),  32'(7'b1101101));
    chk("clamp_seg_units", 32'(seg_units), 32'(7'b1101111));

    // pause / resume
    step(1, 0, 5, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(1);
    step(0, 0, 0, 0, 1);
    idle(10);
    step(0, 0, 0, 1, 0);
    idle(CLK_DIV);

    // pause on the tick edge, then resume
    step(1, 0, 2, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(CLK_DIV - 1);
    step(0, 0, 0, 0, 1);
    idle(3);
    step(0, 0, 0, 1, 0);
    idle(2);

    // load on the edge that would reach 00
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(CLK_DIV - 1);
    step(1, 0, 3, 0, 0);
    idle(2);

    // load 00 then start: stays IDLE
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);

    // asynchronous reset mid-run
    step(1, 3, 4, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(5);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 reset = 1'b1;
    step(0, 0, 0, 1, 0);
    idle(2);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 29) == 0,
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, 15)),
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
